// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch sequencing controller.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2
   } sw_state_e;

   // Smallest width able to hold 0..value-1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) width = i + 1;
      end
      return width;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Button front end: 2-flop synchronizer, stable-sample debouncer and press-edge pulse.
module button_debounce #(
   parameter int unsigned DB_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int unsigned CW = $clog2(DB_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          prev_q;
   logic          armed_q, armed_d;
   logic          press_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // Synchronizer keeps sampling through reset so the true level is known at release.
   always_ff @(posedge clk) begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
   end

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      // A press only counts once the button has been seen released after reset.
      armed_d = armed_q | ~sync2_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DB_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         level_q <= level_d;
         prev_q  <= level_q;
         armed_q <= armed_d;
         press_q <= level_q & ~prev_q & armed_q;
         cnt_q   <= cnt_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: IDLE/RUN/PAUSE FSM, prescaler, digit carry chain and status flags.
// Define STOPWATCH_LAP_EN to build the lap button and the frozen/capture display path.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 100000,
   parameter int unsigned NDIG      = 4,
   parameter int unsigned DB_CYCLES = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            btn_start,
   input  logic            btn_stop,
   input  logic            btn_lap,
   input  logic [NDIG-1:0] digit_max,
   output logic [NDIG-1:0] digit_inc,
   output logic            digit_clr,
   output logic            running,
   output logic            paused,
   output logic            frozen,
   output logic            capture,
   output logic            overflow
);

   localparam int unsigned    PW        = clog2(CLK_DIV);
   localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);

   sw_state_e       state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [NDIG-1:0] inc_q, inc_d;
   logic            clr_q, ovf_q, ovf_d, run_q, pause_q;
   logic            start_p, stop_p;
   logic            tick, clear, carry;

   button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_start),
      .press (start_p)
   );

   button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_stop),
      .press (stop_p)
   );

   assign tick = (state_q == StRun) && (presc_q == PRESC_MAX);

   always_comb begin
      inc_d = '0;
      carry = tick;
      for (int unsigned i = 0; i < NDIG; i++) begin
         inc_d[i] = carry;
         carry    = carry & digit_max[i];
      end
   end

   // Stop outranks start whenever both arrive together.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      clear   = 1'b0;
      ovf_d   = ovf_q | (tick & (&digit_max));
      case (state_q)
         StIdle: begin
            presc_d = '0;
            if (start_p && !stop_p) state_d = StRun;
         end
         StRun: begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (stop_p) state_d = StPause;
         end
         StPause: begin
            if (stop_p) begin
               state_d = StIdle;
               presc_d = '0;
               clear   = 1'b1;
            end else if (start_p) begin
               state_d = StRun;
            end
         end
         default: begin
            state_d = StIdle;
            presc_d = '0;
         end
      endcase
      if (clear) ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         presc_q <= '0;
         inc_q   <= '0;
         clr_q   <= 1'b1;
         ovf_q   <= 1'b0;
         run_q   <= 1'b0;
         pause_q <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         inc_q   <= inc_d;
         clr_q   <= clear;
         ovf_q   <= ovf_d;
         run_q   <= (state_d == StRun);
         pause_q <= (state_d == StPause);
      end
   end

   assign digit_inc = inc_q;
   assign digit_clr = clr_q;
   assign overflow  = ovf_q;
   assign running   = run_q;
   assign paused    = pause_q;

`ifdef STOPWATCH_LAP_EN
   logic lap_p, frz_q, frz_d, cap_q, cap_d;

   button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_lap),
      .press (lap_p)
   );

   always_comb begin
      frz_d = frz_q;
      cap_d = 1'b0;
      if (clear) begin
         frz_d = 1'b0;
      end else if (lap_p) begin
         if (state_q == StRun) begin
            frz_d = ~frz_q;
            cap_d = ~frz_q;
         end else if (state_q == StPause) begin
            frz_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frz_q <= 1'b0;
         cap_q <= 1'b0;
      end else begin
         frz_q <= frz_d;
         cap_q <= cap_d;
      end
   end

   assign frozen  = frz_q;
   assign capture = cap_q;
`else
   logic unused_lap;
   assign unused_lap = btn_lap;
   assign frozen     = 1'b0;
   assign capture    = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with a 2-digit BCD counter pair and a cycle-level reference model.
module tb_stopwatch_ctrl;

   localparam int unsigned CLK_DIV   = 4;
   localparam int unsigned NDIG      = 2;
   localparam int unsigned DB_CYCLES = 3;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_ON = 1'b1;
`else
   localparam bit LAP_ON = 1'b0;
`endif

   logic            clk, reset, btn_start, btn_stop, btn_lap;
   logic [NDIG-1:0] digit_max, digit_inc;
   logic            digit_clr, running, paused, frozen, capture, overflow;
   logic [3:0]      dig0, dig1;
   logic [7:0]      digits;

   int checks   = 0;
   int failures = 0;

   stopwatch_ctrl #(
      .CLK_DIV   (CLK_DIV),
      .NDIG      (NDIG),
      .DB_CYCLES (DB_CYCLES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_start (btn_start),
      .btn_stop  (btn_stop),
      .btn_lap   (btn_lap),
      .digit_max (digit_max),
      .digit_inc (digit_inc),
      .digit_clr (digit_clr),
      .running   (running),
      .paused    (paused),
      .frozen    (frozen),
      .capture   (capture),
      .overflow  (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Digit chain driven by the DUT.
   always_ff @(posedge clk) begin
      if (digit_clr) begin
         dig0 <= 4'd0;
         dig1 <= 4'd0;
      end else begin
         if (digit_inc[0]) dig0 <= (dig0 == 4'd9) ? 4'd0 : dig0 + 4'd1;
         if (digit_inc[1]) dig1 <= (dig1 == 4'd9) ? 4'd0 : dig1 + 4'd1;
      end
   end
   assign digit_max = {dig1 == 4'd9, dig0 == 4'd9};
   assign digits    = {dig1, dig0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Elapsed RUN cycles since the last clear give the tick phase; the tick count gives the digits.
   int         m_state;   // 0 idle, 1 run, 2 pause
   int         m_rc, m_cnt;
   int         m_len [3];
   bit         m_s1 [3], m_s2 [3], m_lvl [3], m_rose [3], m_pv [3];
   bit         m_ovf, m_frz, m_valid;
   logic [1:0] exp_inc;
   bit         exp_clr, exp_cap;

   task automatic model_step();
      logic [2:0] raw;
      bit         seen [3];
      bit         tick, start_p, stop_p, lap_p, prev_frz;
      int         prev_state;
      raw = {btn_lap, btn_stop, btn_start};
      for (int b = 0; b < 3; b++) begin
         seen[b] = m_s2[b];
         m_s2[b] = m_s1[b];
         m_s1[b] = raw[b];
      end
      if (reset) begin
         m_state = 0; m_rc = 0; m_cnt = 0; m_ovf = 0; m_frz = 0;
         exp_inc = 2'b00; exp_clr = 1; exp_cap = 0; m_valid = 1;
         for (int b = 0; b < 3; b++) begin
            m_lvl[b] = 0; m_len[b] = 0; m_rose[b] = 0; m_pv[b] = 0;
         end
      end else begin
         start_p = m_pv[0]; stop_p = m_pv[1]; lap_p = m_pv[2];
         prev_state = m_state; prev_frz = m_frz;
         tick = (m_state == 1) && ((m_rc % CLK_DIV) == CLK_DIV - 1);
         if (m_state == 1) m_rc++;
         exp_inc = 2'b00; exp_clr = 0; exp_cap = 0;
         if (tick) begin
            exp_inc[0] = 1'b1;
            exp_inc[1] = ((m_cnt % 10) == 9);
            if (m_cnt == 99) m_ovf = 1;
            m_cnt = (m_cnt + 1) % 100;
         end
         if (stop_p) begin
            if (m_state == 1) m_state = 2;
            else if (m_state == 2) begin
               m_state = 0; exp_clr = 1; m_rc = 0; m_cnt = 0; m_ovf = 0; m_frz = 0;
            end
         end else if (start_p && m_state != 1) begin
            m_state = 1;
         end
         if (LAP_ON && lap_p && !exp_clr) begin
            if (prev_state == 1) begin
               m_frz   = !prev_frz;
               exp_cap = !prev_frz;
            end else if (prev_state == 2) begin
               m_frz = 0;
            end
         end
         for (int b = 0; b < 3; b++) begin
            m_pv[b]   = m_rose[b];
            m_rose[b] = 0;
            if (seen[b] != m_lvl[b]) begin
               m_len[b]++;
               if (m_len[b] == DB_CYCLES) begin
                  m_lvl[b]  = seen[b];
                  m_len[b]  = 0;
                  m_rose[b] = seen[b];
               end
            end else begin
               m_len[b] = 0;
            end
         end
      end
   endtask

   initial begin
      m_valid = 0;
      for (int b = 0; b < 3; b++) begin
         m_s1[b] = 0; m_s2[b] = 0;
      end
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("digit_inc", {30'd0, digit_inc}, {30'd0, exp_inc});
         chk("digit_clr", {31'd0, digit_clr}, {31'd0, exp_clr});
         chk("running", {31'd0, running}, {31'd0, m_state == 1});
         chk("paused", {31'd0, paused}, {31'd0, m_state == 2});
         chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
         chk("frozen", {31'd0, frozen}, {31'd0, m_frz});
         chk("capture", {31'd0, capture}, {31'd0, exp_cap});
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // sel: 0 running, 1 paused, 2 digit_inc[0], 3 digit_clr, 4 overflow, 5 digit_inc==11
   task automatic await(input string name, input int sel, input int budget, output int n);
      bit hit;
      hit = 0;
      n   = 0;
      while (!hit && n < budget) begin
         @(negedge clk);
         n++;
         case (sel)
            0:       hit = running;
            1:       hit = paused;
            2:       hit = digit_inc[0];
            3:       hit = digit_clr;
            4:       hit = overflow;
            default: hit = (digit_inc == 2'b11);
         endcase
      end
      chk({name, "_seen"}, {31'd0, hit}, 32'd1);
      if (!hit) n = -1;
   endtask

   initial begin
      int n, incs, caps;
      reset = 1'b1; btn_start = 1'b0; btn_stop = 1'b0; btn_lap = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("reset_clr", {31'd0, digit_clr}, 32'd1);
      end
      reset = 1'b0;
      @(negedge clk);
      chk("clr_release", {31'd0, digit_clr}, 32'd0);
      chk("reset_digits", {24'd0, digits}, 32'h00);
      chk("reset_running", {31'd0, running}, 32'd0);

      // Start: press pulse DB+3 after the edge, state one later.
      btn_start = 1'b1;
      await("start", 0, 40, n);
      chk("start_latency", n, 7);
      await("first_tick", 2, 20, n);
      chk("first_tick_delay", n, 4);
      btn_start = 1'b0;
      await("tick2", 2, 20, n);
      chk("tick_period", n, 4);
      await("carry", 5, 100, n);
      chk("carry_before", {24'd0, digits}, 32'h09);
      @(negedge clk);
      chk("carry_after", {24'd0, digits}, 32'h10);

      // Pause with prescaler held at 1, then resume.
      await("align", 2, 20, n);
      cyc(2);
      btn_stop = 1'b1;
      await("pause", 1, 40, n);
      chk("stop_latency", n, 7);
      incs = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 4) btn_stop = 1'b0;
         @(negedge clk);
         incs += int'(digit_inc != 2'b00);
      end
      chk("paused_no_ticks", incs, 0);
      btn_start = 1'b1;
      await("resume", 0, 40, n);
      await("resume_tick", 2, 20, n);
      chk("resume_first_tick", n, 3);
      btn_start = 1'b0;

      // Run to full scale and wrap.
      await("overflow", 4, 2000, n);
      chk("wrap_inc", {30'd0, digit_inc}, 32'd3);
      chk("wrap_before", {24'd0, digits}, 32'h99);
      @(negedge clk);
      chk("wrap_after", {24'd0, digits}, 32'h00);

      // PAUSE then stop again clears everything.
      btn_stop = 1'b1;
      await("pause2", 1, 40, n);
      cyc(3);
      btn_stop = 1'b0;
      cyc(8);
      btn_stop = 1'b1;
      await("clear", 3, 40, n);
      chk("clr_latency", n, 7);
      @(negedge clk);
      chk("clr_width", {31'd0, digit_clr}, 32'd0);
      chk("clr_overflow", {31'd0, overflow}, 32'd0);
      chk("clr_idle", {30'd0, running, paused}, 32'd0);
      chk("clr_digits", {24'd0, digits}, 32'h00);
      btn_stop = 1'b0;
      cyc(8);

      // Start and stop together while running: stop wins.
      btn_start = 1'b1;
      await("start3", 0, 40, n);
      cyc(3);
      btn_start = 1'b0;
      cyc(8);
      btn_start = 1'b1;
      btn_stop  = 1'b1;
      cyc(10);
      chk("simul_paused", {30'd0, running, paused}, 32'd1);
      btn_start = 1'b0;
      btn_stop  = 1'b0;
      cyc(8);

      // Short glitch is rejected.
      btn_start = 1'b1;
      cyc(2);
      btn_start = 1'b0;
      cyc(15);
      chk("glitch_ignored", {30'd0, running, paused}, 32'd1);

      // Lap toggles freeze while running.
      btn_start = 1'b1;
      await("start4", 0, 40, n);
      cyc(3);
      btn_start = 1'b0;
      cyc(5);
      btn_lap = 1'b1;
      caps = 0; incs = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         caps += int'(capture);
         incs += int'(digit_inc[0]);
      end
      chk("lap1_frozen", {31'd0, frozen}, {31'd0, LAP_ON});
      chk("lap1_capture", caps, LAP_ON ? 1 : 0);
      chk("lap1_counting", {31'd0, incs >= 2}, 32'd1);
      btn_lap = 1'b0;
      cyc(8);
      btn_lap = 1'b1;
      caps = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         caps += int'(capture);
      end
      chk("lap2_frozen", {31'd0, frozen}, 32'd0);
      chk("lap2_capture", caps, 0);
      btn_lap = 1'b0;
      cyc(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
